// File: rtl/nanotrade_pkg.sv
// Shared definitions for the order path.
//   cb_state_e     : circuit-breaker state encoding driven by the breaker
//   side_e         : order side encoding (bid / ask)
//   order_rec_bits : width of a packed {side, price, qty} order record
package nanotrade_pkg;

   typedef enum logic [1:0] {
      S_NORMAL   = 2'b00,
      S_THROTTLE = 2'b01,
      S_WIDEN    = 2'b10,
      S_PAUSE    = 2'b11
   } cb_state_e;

   typedef enum logic {
      SIDE_BID = 1'b0,
      SIDE_ASK = 1'b1
   } side_e;

   function automatic int order_rec_bits(input int price_bits, input int qty_bits);
      return 1 + price_bits + qty_bits;
   endfunction

endpackage

// File: rtl/order_fifo.sv
// Small synchronous FIFO of packed order records.
//   clk_i, rst_ni : clock, asynchronous active-low reset (clears pointers/level)
//   push_i        : write wdata_i at the tail (ignored when full)
//   pop_i         : remove the head (released downstream)
//   drop_head_i   : remove the head (discarded)
//   head_o        : record currently at the head
//   head_ready_o  : head present and old enough to be released
//   level_o       : occupancy, full_o / empty_o : occupancy flags
module order_fifo
   import nanotrade_pkg::*;
#(
   parameter int WIDTH = 33,
   parameter int DEPTH = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   push_i,
   input  logic [WIDTH-1:0]       wdata_i,
   input  logic                   pop_i,
   input  logic                   drop_head_i,
   output logic [WIDTH-1:0]       head_o,
   output logic                   head_ready_o,
   output logic [$clog2(DEPTH):0] level_o,
   output logic                   full_o,
   output logic                   empty_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             head_new_q, head_new_d;
   logic             do_push, do_remove;

   assign full_o    = (level_q == LVL_W'(DEPTH));
   assign empty_o   = (level_q == '0);
   assign do_push   = push_i && !full_o;
   assign do_remove = (pop_i || drop_head_i) && !empty_o;

   assign head_o       = mem_q[rd_ptr_q];
   assign level_o      = level_q;
   // An entry written at the last edge that landed straight at the head is
   // not releasable yet: there is no bypass from ingress to the output stage.
   assign head_ready_o = !empty_o && !head_new_q;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      // The pushed entry is the head after this edge iff nothing else remains.
      head_new_d = do_push && (level_q == LVL_W'(do_remove));
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (do_remove) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_remove})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         head_new_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         head_new_q <= head_new_d;
      end
   end

   // Storage carries no reset; validity is tracked by the pointers and level.
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/order_admission_gate.sv
// Admission gate between the breaker-controlled ingress and the matching book.
// Orders queue in a FIFO; one leaves per allow_order credit into a
// valid/ready output register. Orders stuck at the head are aged out.
//   clk_i, rst_ni              : clock, asynchronous active-low reset
//   in_valid_i / in_ready_o    : ingress handshake, with in_side/price/qty_i
//   cb_state_i, allow_order_i  : breaker state and one-cycle release credit
//   out_valid_o / out_ready_i  : book handshake, with out_side/price/qty_o
//   fifo_level_o               : queue occupancy
//   drop_count_o, stale_count_o: saturating discard counters (full / aged)
//   paused_hold_o              : breaker paused while orders are queued
module order_admission_gate
   import nanotrade_pkg::*;
#(
   parameter int PRICE_BITS   = 16,
   parameter int QTY_BITS     = 16,
   parameter int DEPTH        = 4,
   parameter int MAX_AGE      = 64,
   parameter int DROP_ON_FULL = 0
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   in_valid_i,
   output logic                   in_ready_o,
   input  logic                   in_side_i,
   input  logic [PRICE_BITS-1:0]  in_price_i,
   input  logic [QTY_BITS-1:0]    in_qty_i,
   input  logic [1:0]             cb_state_i,
   input  logic                   allow_order_i,
   output logic                   out_valid_o,
   input  logic                   out_ready_i,
   output logic                   out_side_o,
   output logic [PRICE_BITS-1:0]  out_price_o,
   output logic [QTY_BITS-1:0]    out_qty_o,
   output logic [$clog2(DEPTH):0] fifo_level_o,
   output logic [15:0]            drop_count_o,
   output logic [15:0]            stale_count_o,
   output logic                   paused_hold_o
);

   localparam int REC_W    = order_rec_bits(PRICE_BITS, QTY_BITS);
   localparam int AGE_W    = (MAX_AGE <= 2) ? 1 : $clog2(MAX_AGE);
   localparam int AGE_LAST = (MAX_AGE == 0) ? 0 : MAX_AGE - 1;
   localparam logic [15:0] CNT_MAX = 16'hFFFF;

   logic [REC_W-1:0]      head;
   logic                  head_ready, fifo_full, fifo_empty;
   logic                  push, pop, stale, arrival_drop;

   logic                  out_valid_q, out_valid_d;
   side_e                 out_side_q, out_side_d;
   logic [PRICE_BITS-1:0] out_price_q, out_price_d;
   logic [QTY_BITS-1:0]   out_qty_q, out_qty_d;
   logic [AGE_W-1:0]      head_age_q, head_age_d;
   logic [15:0]           drop_count_q, drop_count_d;
   logic [15:0]           stale_count_q, stale_count_d;

   assign in_ready_o   = (DROP_ON_FULL != 0) ? 1'b1 : !fifo_full;
   assign push         = in_valid_i && in_ready_o && !fifo_full;
   // In drop mode the arrival is lost whenever the queue is full at the edge,
   // even if the head leaves in the same cycle.
   assign arrival_drop = (DROP_ON_FULL != 0) && in_valid_i && fifo_full;
   // Credit is consumed only if it can be used right now; it is never banked.
   assign pop          = allow_order_i && head_ready && (!out_valid_q || out_ready_i);
   // A release in the same cycle wins over ageing out.
   assign stale        = (MAX_AGE != 0) && !fifo_empty && !pop &&
                         (head_age_q == AGE_W'(AGE_LAST));

   order_fifo #(
      .WIDTH (REC_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .push_i       (push),
      .wdata_i      ({in_side_i, in_price_i, in_qty_i}),
      .pop_i        (pop),
      .drop_head_i  (stale),
      .head_o       (head),
      .head_ready_o (head_ready),
      .level_o      (fifo_level_o),
      .full_o       (fifo_full),
      .empty_o      (fifo_empty)
   );

   always_comb begin
      out_valid_d   = out_valid_q;
      out_side_d    = out_side_q;
      out_price_d   = out_price_q;
      out_qty_d     = out_qty_q;
      head_age_d    = head_age_q;
      drop_count_d  = drop_count_q;
      stale_count_d = stale_count_q;

      if (pop) begin
         out_valid_d = 1'b1;
         out_side_d  = side_e'(head[REC_W-1]);
         out_price_d = head[PRICE_BITS+QTY_BITS-1:QTY_BITS];
         out_qty_d   = head[QTY_BITS-1:0];
      end else if (out_ready_i) begin
         out_valid_d = 1'b0;
      end

      // Age tracks how long the current head has been waiting.
      if (fifo_empty || pop || stale) begin
         head_age_d = '0;
      end else begin
         head_age_d = head_age_q + AGE_W'(1);
      end

      if (arrival_drop && (drop_count_q != CNT_MAX)) begin
         drop_count_d = drop_count_q + 16'd1;
      end
      if (stale && (stale_count_q != CNT_MAX)) begin
         stale_count_d = stale_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         out_valid_q   <= 1'b0;
         out_side_q    <= SIDE_BID;
         out_price_q   <= '0;
         out_qty_q     <= '0;
         head_age_q    <= '0;
         drop_count_q  <= '0;
         stale_count_q <= '0;
      end else begin
         out_valid_q   <= out_valid_d;
         out_side_q    <= out_side_d;
         out_price_q   <= out_price_d;
         out_qty_q     <= out_qty_d;
         head_age_q    <= head_age_d;
         drop_count_q  <= drop_count_d;
         stale_count_q <= stale_count_d;
      end
   end

   assign out_valid_o   = out_valid_q;
   assign out_side_o    = out_side_q;
   assign out_price_o   = out_price_q;
   assign out_qty_o     = out_qty_q;
   assign drop_count_o  = drop_count_q;
   assign stale_count_o = stale_count_q;
   assign paused_hold_o = (cb_state_e'(cb_state_i) == S_PAUSE) && (fifo_level_o != '0);

endmodule

// File: tb/tb_order_admission_gate.sv
// Bench for order_admission_gate: instance A (backpressure, long ageing) and
// instance B (drop-on-full, MAX_AGE=8) driven side by side, checked against a
// queue-level reference model every cycle plus directed literal expectations.
`timescale 1ns/1ps
module tb_order_admission_gate;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // Stimulus, index 0 = instance A, 1 = instance B
   logic        in_valid [2];
   logic        in_side [2];
   logic [15:0] in_price [2];
   logic [15:0] in_qty [2];
   logic [1:0]  cb [2];
   logic        allow [2];
   logic        out_ready [2];

   logic        in_ready_a, out_valid_a, out_side_a, paused_hold_a;
   logic [15:0] out_price_a, out_qty_a, drop_count_a, stale_count_a;
   logic [2:0]  fifo_level_a;
   logic        in_ready_b, out_valid_b, out_side_b, paused_hold_b;
   logic [15:0] out_price_b, out_qty_b, drop_count_b, stale_count_b;
   logic [2:0]  fifo_level_b;

   order_admission_gate #(
      .PRICE_BITS(16), .QTY_BITS(16), .DEPTH(4), .MAX_AGE(64), .DROP_ON_FULL(0)
   ) dut_a (
      .clk_i(clk), .rst_ni(rst_n),
      .in_valid_i(in_valid[0]), .in_ready_o(in_ready_a), .in_side_i(in_side[0]),
      .in_price_i(in_price[0]), .in_qty_i(in_qty[0]), .cb_state_i(cb[0]),
      .allow_order_i(allow[0]), .out_valid_o(out_valid_a), .out_ready_i(out_ready[0]),
      .out_side_o(out_side_a), .out_price_o(out_price_a), .out_qty_o(out_qty_a),
      .fifo_level_o(fifo_level_a), .drop_count_o(drop_count_a),
      .stale_count_o(stale_count_a), .paused_hold_o(paused_hold_a)
   );

   order_admission_gate #(
      .PRICE_BITS(16), .QTY_BITS(16), .DEPTH(4), .MAX_AGE(8), .DROP_ON_FULL(1)
   ) dut_b (
      .clk_i(clk), .rst_ni(rst_n),
      .in_valid_i(in_valid[1]), .in_ready_o(in_ready_b), .in_side_i(in_side[1]),
      .in_price_i(in_price[1]), .in_qty_i(in_qty[1]), .cb_state_i(cb[1]),
      .allow_order_i(allow[1]), .out_valid_o(out_valid_b), .out_ready_i(out_ready[1]),
      .out_side_o(out_side_b), .out_price_o(out_price_b), .out_qty_o(out_qty_b),
      .fifo_level_o(fifo_level_b), .drop_count_o(drop_count_b),
      .stale_count_o(stale_count_b), .paused_hold_o(paused_hold_b)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   // ---------------- reference model: list of waiting orders ----------------
   int          DOF [2] = '{0, 1};
   int          MA [2]  = '{64, 8};
   logic [32:0] mrec [2][4];     // waiting orders, index 0 is the oldest
   int          mstamp [2][4];   // edge number at which each order was accepted
   int          mcnt [2];
   int          mwait [2];       // cycles the oldest order has spent at the front
   bit          mov [2];
   logic [32:0] mout [2];
   int          mdrop [2];
   int          mstale [2];
   int          edge_no;

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         mcnt[i] = 0; mwait[i] = 0; mov[i] = 0; mout[i] = '0;
         mdrop[i] = 0; mstale[i] = 0;
      end
   endtask

   task automatic model_edge(input int i);
      int n;
      bit full, rel, aged, take, lost;
      n    = mcnt[i];
      full = (n == 4);
      // release needs a credit, an order accepted at least two edges ago,
      // and a free output slot
      rel  = allow[i] && (n > 0) && (mstamp[i][0] <= edge_no - 2) && (!mov[i] || out_ready[i]);
      aged = (MA[i] != 0) && !rel && (n > 0) && (mwait[i] == MA[i] - 1);
      take = in_valid[i] && !full;
      lost = (DOF[i] != 0) && in_valid[i] && full;
      if (rel) begin
         mout[i] = mrec[i][0];
         mov[i]  = 1;
      end else if (out_ready[i]) begin
         mov[i] = 0;
      end
      if (n == 0 || rel || aged) mwait[i] = 0;
      else mwait[i] = mwait[i] + 1;
      if (rel || aged) begin
         for (int k = 0; k < 3; k++) begin
            mrec[i][k]   = mrec[i][k+1];
            mstamp[i][k] = mstamp[i][k+1];
         end
         n = n - 1;
      end
      if (aged && mstale[i] < 65535) mstale[i] = mstale[i] + 1;
      if (take) begin
         mrec[i][n]   = {in_side[i], in_price[i], in_qty[i]};
         mstamp[i][n] = edge_no;
         n = n + 1;
      end
      if (lost && mdrop[i] < 65535) mdrop[i] = mdrop[i] + 1;
      mcnt[i] = n;
   endtask

   initial begin
      edge_no = 0;
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else begin
            edge_no++;
            for (int i = 0; i < 2; i++) model_edge(i);
         end
      end
   end

   task automatic compare_inst(input int i, input logic ov, input logic rdy, input logic sd,
                               input logic [15:0] pr, input logic [15:0] qt, input logic [2:0] lvl,
                               input logic [15:0] dc, input logic [15:0] sc, input logic ph);
      string p;
      p = (i == 0) ? "A" : "B";
      chk({p, ".in_ready"},    rdy, (DOF[i] != 0) ? 1 : (mcnt[i] < 4));
      chk({p, ".fifo_level"},  lvl, mcnt[i]);
      chk({p, ".out_valid"},   ov,  mov[i]);
      chk({p, ".out_side"},    sd,  mout[i][32]);
      chk({p, ".out_price"},   pr,  mout[i][31:16]);
      chk({p, ".out_qty"},     qt,  mout[i][15:0]);
      chk({p, ".drop_count"},  dc,  mdrop[i]);
      chk({p, ".stale_count"}, sc,  mstale[i]);
      chk({p, ".paused_hold"}, ph,  (cb[i] == 2'b11) && (mcnt[i] != 0));
   endtask

   // Single compare process: every falling edge, both instances vs the model.
   initial begin
      forever begin
         @(negedge clk);
         compare_inst(0, out_valid_a, in_ready_a, out_side_a, out_price_a, out_qty_a,
                      fifo_level_a, drop_count_a, stale_count_a, paused_hold_a);
         compare_inst(1, out_valid_b, in_ready_b, out_side_b, out_price_b, out_qty_b,
                      fifo_level_b, drop_count_b, stale_count_b, paused_hold_b);
         if (out_valid_a && out_ready[0])
            $display("A release side=%0d price=%0d qty=%0d", out_side_a, out_price_a, out_qty_a);
         if (out_valid_b && out_ready[1])
            $display("B release side=%0d price=%0d qty=%0d", out_side_b, out_price_b, out_qty_b);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, got running required finished");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ------------------------------- directed ---------------------------------
   int seen;
   int npulse;
   int pulse_at [4];

   initial begin
      for (int i = 0; i < 2; i++) begin
         in_valid[i] = 0; in_side[i] = 0; in_price[i] = 0; in_qty[i] = 0;
         cb[i] = 2'b00; allow[i] = 0; out_ready[i] = 0;
      end

      // 1. reset with in_valid and allow_order held high
      in_valid[0] = 1; allow[0] = 1; in_valid[1] = 1; allow[1] = 1;
      repeat (3) tick();
      chk("t1_out_valid", out_valid_a, 0);
      chk("t1_level", fifo_level_a, 0);
      chk("t1_in_ready", in_ready_a, 1);
      chk("t1_drop", drop_count_a, 0);
      chk("t1_stale", stale_count_a, 0);
      chk("t1_b_level", fifo_level_b, 0);
      in_valid[0] = 0; allow[0] = 0; in_valid[1] = 0; allow[1] = 0;
      tick();
      rst_n = 1;
      tick();

      // 2. pass-through: bid 100 x 5, out_valid at edge N+2, then held stable
      in_valid[0] = 1; in_side[0] = 0; in_price[0] = 100; in_qty[0] = 5; allow[0] = 1;
      tick();   // edge N
      in_valid[0] = 0;
      chk("t2_no_valid_N", out_valid_a, 0);
      tick();   // edge N+1
      chk("t2_no_valid_N1", out_valid_a, 0);
      tick();   // edge N+2
      chk("t2_valid_N2", out_valid_a, 1);
      chk("t2_order", {out_side_a, out_price_a, out_qty_a}, {1'b0, 16'd100, 16'd5});
      for (int c = 0; c < 10; c++) begin
         tick();
         chk("t2_hold", {out_valid_a, out_side_a, out_price_a, out_qty_a},
             {1'b1, 1'b0, 16'd100, 16'd5});
      end
      out_ready[0] = 1;
      tick();
      chk("t2_accepted", out_valid_a, 0);
      allow[0] = 0;

      // 3. PAUSE backpressure: six offered, four accepted, then released in order
      cb[0] = 2'b11;
      for (int k = 0; k < 6; k++) begin
         in_valid[0] = 1; in_side[0] = k[0]; in_price[0] = 16'(200 + k); in_qty[0] = 16'(k + 1);
         chk("t3_in_ready", in_ready_a, (k < 4));
         tick();
      end
      in_valid[0] = 0;
      chk("t3_level", fifo_level_a, 4);
      chk("t3_paused_hold", paused_hold_a, 1);
      chk("t3_in_ready_low", in_ready_a, 0);
      cb[0] = 2'b00; allow[0] = 1;
      seen = 0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (out_valid_a) begin
            if (seen < 4) chk("t3_order", out_price_a, 200 + seen);
            seen++;
         end
      end
      chk("t3_released", seen, 4);
      allow[0] = 0;

      // 5. THROTTLE: one credit every 4 cycles releases one order each
      cb[0] = 2'b01;
      for (int k = 0; k < 3; k++) begin
         in_valid[0] = 1; in_side[0] = 1; in_price[0] = 16'(300 + k); in_qty[0] = 16'd7;
         tick();
      end
      in_valid[0] = 0;
      repeat (2) tick();
      npulse = 0;
      for (int c = 0; c < 16; c++) begin
         allow[0] = ((c % 4) == 0);
         tick();
         if (out_valid_a) begin
            if (npulse < 4) pulse_at[npulse] = c;
            npulse++;
         end
      end
      allow[0] = 0;
      chk("t5_pulses", npulse, 3);
      chk("t5_pulse0", pulse_at[0], 0);
      chk("t5_pulse1", pulse_at[1], 4);
      chk("t5_pulse2", pulse_at[2], 8);

      // credit arriving while the output stage is stalled is lost
      out_ready[0] = 0;
      for (int k = 0; k < 2; k++) begin
         in_valid[0] = 1; in_side[0] = 0; in_price[0] = 16'(310 + k); in_qty[0] = 16'd2;
         tick();
      end
      in_valid[0] = 0;
      repeat (2) tick();
      allow[0] = 1; tick(); allow[0] = 0;
      chk("t5_first_out", {out_valid_a, out_price_a}, {1'b1, 16'd310});
      repeat (2) tick();
      allow[0] = 1; tick(); allow[0] = 0;
      chk("t5_stalled_level", fifo_level_a, 1);
      chk("t5_stalled_out", out_price_a, 310);
      out_ready[0] = 1;
      tick();
      chk("t5_no_banked_credit", out_valid_a, 0);
      chk("t5_still_queued", fifo_level_a, 1);
      allow[0] = 1; tick(); allow[0] = 0;
      chk("t5_second_out", {out_valid_a, out_price_a}, {1'b1, 16'd311});
      tick();
      cb[0] = 2'b00;

      // 4. drop-on-full (B): 7 offered with no credit, 3 discarded
      out_ready[1] = 1;
      for (int k = 0; k < 7; k++) begin
         in_valid[1] = 1; in_side[1] = 1; in_price[1] = 16'(400 + k); in_qty[1] = 16'd9;
         chk("t4_in_ready", in_ready_b, 1);
         tick();
      end
      in_valid[1] = 0;
      chk("t4_drop_count", drop_count_b, 3);
      chk("t4_level", fifo_level_b, 4);

      // reset mid-operation clears queue and counters immediately
      rst_n = 0;
      #1;
      chk("rst_b_level", fifo_level_b, 0);
      chk("rst_b_drop", drop_count_b, 0);
      tick();
      rst_n = 1;
      tick();

      // 6. ageing (B, MAX_AGE=8): two orders, no credit
      for (int k = 0; k < 2; k++) begin
         in_valid[1] = 1; in_side[1] = 0; in_price[1] = 16'(500 + k); in_qty[1] = 16'd1;
         tick();   // edges t=0, t=1
      end
      in_valid[1] = 0;
      for (int t = 2; t <= 18; t++) begin
         tick();
         if (t == 7)  chk("t6_level_t7", fifo_level_b, 2);
         if (t == 8)  chk("t6_t8", {13'd0, fifo_level_b, stale_count_b}, {13'd0, 3'd1, 16'd1});
         if (t == 15) chk("t6_level_t15", fifo_level_b, 1);
         if (t == 16) chk("t6_t16", {13'd0, fifo_level_b, stale_count_b}, {13'd0, 3'd0, 16'd2});
      end
      chk("t6_stale_final", stale_count_b, 2);
      chk("t6_no_output", out_valid_b, 0);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
